// File: rtl/bkm_tb_pkg.sv
// Shared encodings for the BKM control-step stimulus generator: digit codes,
// FSM states, LFSR feedback mask and default seeds.
package bkm_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Signed-digit codes; 2'b10 is never driven.
  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_NEG  = 2'b11;

  // Right-shifting Galois mask for x^64 + x^63 + x^61 + x^60 + 1.
  localparam logic [63:0] LFSR_POLY      = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED_U = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DEFAULT_SEED_V = 64'hFEDC_BA98_7654_3210;

  function automatic logic [1:0] map_digit(input logic [1:0] raw);
    return (raw == 2'b10) ? D_ZERO : raw;
  endfunction

endpackage

// File: rtl/bkm_lfsr64.sv
// 64-bit right-shifting Galois LFSR; exposes the value it will take on the
// next advance so the parent can register it in the same cycle.
module bkm_lfsr64
  import bkm_tb_pkg::*;
#(
  parameter logic [63:0] SEED = DEFAULT_SEED_U
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        load,
  input  logic        advance,
  output logic [63:0] state_nxt
);

  logic [63:0] state_q;

  always_comb begin
    state_nxt = {1'b0, state_q[63:1]} ^ (state_q[0] ? LFSR_POLY : 64'h0);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= state_nxt;
    end
  end

endmodule

// File: rtl/bkm_control_step_stim.sv
// Stimulus generator for bkm_control_step: issues NUM_VEC step vectors per run
// and a LATENCY-aligned chk_enable for the checker.
module bkm_control_step_stim
  import bkm_tb_pkg::*;
#(
  parameter int unsigned W       = 64,
  parameter int unsigned LOG2N   = 6,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned NUM_VEC = 1024,
  parameter logic [63:0] SEED_U  = DEFAULT_SEED_U,
  parameter logic [63:0] SEED_V  = DEFAULT_SEED_V
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [1:0]       cfg_format,
  output logic             tb_mode,
  output logic [1:0]       tb_format,
  output logic [LOG2N-1:0] tb_n,
  output logic [1:0]       tb_d_u_n,
  output logic [1:0]       tb_d_v_n,
  output logic [W-1:0]     tb_u_n,
  output logic [W-1:0]     tb_v_n,
  output logic             vec_vld,
  output logic             chk_enable,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_cnt
);

  localparam logic [3:0] DRAIN_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef struct packed {
    logic             mode;
    logic [1:0]       format;
    logic [LOG2N-1:0] n;
    logic [1:0]       d_u;
    logic [1:0]       d_v;
    logic [W-1:0]     u;
    logic [W-1:0]     v;
  } vec_t;

  state_t      state, state_nxt;
  vec_t        vec_q;
  logic [3:0]  drain_cnt;
  logic [63:0] lfsr_u_nxt, lfsr_v_nxt;
  logic        run_done, start_run, issue;

  assign run_done  = (vec_cnt == 16'(NUM_VEC));
  assign start_run = (state == ST_IDLE) && start;
  assign issue     = start_run || ((state == ST_RUN) && !run_done);

  bkm_lfsr64 #(.SEED(SEED_U)) u_lfsr_u (
    .clk       (clk),
    .arst      (arst),
    .load      (srst),
    .advance   (enable && issue),
    .state_nxt (lfsr_u_nxt)
  );

  bkm_lfsr64 #(.SEED(SEED_V)) u_lfsr_v (
    .clk       (clk),
    .arst      (arst),
    .load      (srst),
    .advance   (enable && issue),
    .state_nxt (lfsr_v_nxt)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state <= ST_IDLE;
    end else if (srst) begin
      state <= ST_IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // NOTE: default assignment first, so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (run_done) state_nxt = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  // Vector k is loaded on the edge that issues it, so tb_* are flop outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      vec_q     <= '0;
      vec_vld   <= 1'b0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else if (srst) begin
      vec_q     <= '0;
      vec_vld   <= 1'b0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else if (enable) begin
      vec_vld <= issue;
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 4'd1;
      else                   drain_cnt <= '0;
      if (start_run) begin
        vec_q.mode   <= cfg_mode;
        vec_q.format <= cfg_format;
        vec_q.n      <= '0;
        vec_cnt      <= 16'd1;
      end else if (issue) begin
        vec_q.n <= vec_q.n + LOG2N'(1);
        vec_cnt <= vec_cnt + 16'd1;
      end
      if (issue) begin
        vec_q.u   <= lfsr_u_nxt[W-1:0];
        vec_q.v   <= lfsr_v_nxt[W-1:0];
        vec_q.d_u <= map_digit(lfsr_u_nxt[63:62]);
        vec_q.d_v <= map_digit(lfsr_u_nxt[61:60]);
      end
    end
  end

  assign tb_mode   = vec_q.mode;
  assign tb_format = vec_q.format;
  assign tb_n      = vec_q.n;
  assign tb_d_u_n  = vec_q.d_u;
  assign tb_d_v_n  = vec_q.d_v;
  assign tb_u_n    = vec_q.u;
  assign tb_v_n    = vec_q.v;

  generate
    if (LATENCY == 0) begin : g_no_delay
      assign chk_enable = vec_vld;
    end else begin : g_delay
      logic [LATENCY-1:0] vld_pipe;
      // NOTE: the delay line is reset like any flop; a stale 1 would fire the checker.
      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          vld_pipe <= '0;
        end else if (srst) begin
          vld_pipe <= '0;
        end else if (enable) begin
          vld_pipe <= (vld_pipe << 1) | LATENCY'(vec_vld);
        end
      end
      assign chk_enable = vld_pipe[LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_bkm_control_step_stim.sv
// Scoreboard bench for bkm_control_step_stim: expected vectors are queued when a
// start is sampled and popped whenever the generator presents a new vector.
module tb_bkm_control_step_stim;

  localparam int W     = 64;
  localparam int LOG2N = 2;
  localparam int LAT   = 2;
  localparam int NV    = 6;
  localparam logic [63:0] SEED_U = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEED_V = 64'hFEDC_BA98_7654_3210;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             srst = 1'b0;
  logic             enable = 1'b1;
  logic             start = 1'b0;
  logic             cfg_mode = 1'b0;
  logic [1:0]       cfg_format = 2'b00;
  logic             tb_mode;
  logic [1:0]       tb_format;
  logic [LOG2N-1:0] tb_n;
  logic [1:0]       tb_d_u_n, tb_d_v_n;
  logic [W-1:0]     tb_u_n, tb_v_n;
  logic             vec_vld, chk_enable, busy, done;
  logic [15:0]      vec_cnt;

  bkm_control_step_stim #(
    .W(W), .LOG2N(LOG2N), .LATENCY(LAT), .NUM_VEC(NV), .SEED_U(SEED_U), .SEED_V(SEED_V)
  ) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
    .cfg_mode(cfg_mode), .cfg_format(cfg_format),
    .tb_mode(tb_mode), .tb_format(tb_format), .tb_n(tb_n),
    .tb_d_u_n(tb_d_u_n), .tb_d_v_n(tb_d_v_n), .tb_u_n(tb_u_n), .tb_v_n(tb_v_n),
    .vec_vld(vec_vld), .chk_enable(chk_enable), .busy(busy), .done(done), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             mode;
    logic [1:0]       format;
    logic [LOG2N-1:0] n;
    logic [1:0]       du;
    logic [1:0]       dv;
    logic [W-1:0]     u;
    logic [W-1:0]     v;
  } exp_vec_t;

  exp_vec_t    sb_q[$];
  exp_vec_t    last;
  logic [63:0] m_u, m_v;
  int          e, e0, run_vld, vec_seen;
  bit          started;
  int          seen_du[4], seen_dv[4];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_step(input logic [63:0] s);
    logic [63:0] r;
    r = s >> 1;
    if (s[0]) begin
      r[63] = ~r[63];
      r[62] = ~r[62];
      r[60] = ~r[60];
      r[59] = ~r[59];
    end
    return r;
  endfunction

  function automatic logic [1:0] model_digit(input logic [1:0] raw);
    case (raw)
      2'b01:   return 2'b01;
      2'b11:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit model_idle();
    return !started || (e >= e0 + NV + LAT + 1);
  endfunction

  task automatic model_reset();
    m_u = SEED_U;
    m_v = SEED_V;
    started = 0;
    e = 0;
    e0 = 0;
    sb_q.delete();
    last = '0;
  endtask

  task automatic push_run(input logic mode, input logic [1:0] fmt);
    exp_vec_t x;
    for (int k = 0; k < NV; k++) begin
      m_u = model_step(m_u);
      m_v = model_step(m_v);
      x.mode   = mode;
      x.format = fmt;
      x.n      = LOG2N'(k);
      x.u      = m_u[W-1:0];
      x.v      = m_v[W-1:0];
      x.du     = model_digit(m_u[63:62]);
      x.dv     = model_digit(m_u[61:60]);
      sb_q.push_back(x);
    end
  endtask

  task automatic compare(input bit new_edge);
    int exp_cnt;
    exp_cnt = !started ? 0 : ((e - e0 + 1 < NV) ? e - e0 + 1 : NV);
    check("vec_vld", vec_vld, started && e >= e0 && e <= e0 + NV - 1);
    check("chk_enable", chk_enable, started && e >= e0 + LAT && e <= e0 + NV - 1 + LAT);
    check("done", done, started && e == e0 + NV + LAT);
    check("busy", busy, started && e >= e0 && e <= e0 + NV + LAT - 1);
    check("vec_cnt", vec_cnt, exp_cnt);
    if (vec_vld && new_edge) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        last = sb_q.pop_front();
        run_vld++;
        vec_seen++;
        seen_du[tb_d_u_n]++;
        seen_dv[tb_d_v_n]++;
        check("d_u_legal", tb_d_u_n == 2'b10, 0);
        check("d_v_legal", tb_d_v_n == 2'b10, 0);
      end
    end
    check("tb_mode", tb_mode, last.mode);
    check("tb_format", tb_format, last.format);
    check("tb_n", tb_n, last.n);
    check("tb_d_u_n", tb_d_u_n, last.du);
    check("tb_d_v_n", tb_d_v_n, last.dv);
    check("tb_u_n", tb_u_n, last.u);
    check("tb_v_n", tb_v_n, last.v);
  endtask

  task automatic step();
    logic en_edge, rst_edge, st_edge, mode_edge;
    logic [1:0] fmt_edge;
    bit idle_before;
    en_edge     = enable;
    rst_edge    = srst || !arst;
    st_edge     = start;
    mode_edge   = cfg_mode;
    fmt_edge    = cfg_format;
    idle_before = model_idle();
    @(posedge clk);
    #1;
    if (rst_edge) begin
      model_reset();
    end else if (en_edge) begin
      e++;
      if (idle_before && st_edge) begin
        e0 = e;
        started = 1;
        run_vld = 0;
        push_run(mode_edge, fmt_edge);
      end
    end
    compare(en_edge && !rst_edge);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    run_vld = 0;
    vec_seen = 0;
    #2 arst = 1'b0;
    repeat (2) step();
    arst = 1'b1;

    // Single run: done timing, vec_cnt, tb_n wrap, first operand after reset.
    cfg_mode = 1'b1;
    cfg_format = 2'b10;
    start = 1'b1;
    step();
    start = 1'b0;
    check("first_u_after_reset", tb_u_n, model_step(SEED_U));
    repeat (NV + LAT + 3) step();

    // Freeze for three cycles while vector 2 is on the outputs.
    cfg_mode = 1'b0;
    cfg_format = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (NV + LAT + 2) step();
    check("freeze_vec_count", run_vld, NV);

    // Back-to-back runs with start held: operands continue the LFSR sequence.
    cfg_format = 2'b11;
    start = 1'b1;
    repeat (2 * (NV + LAT + 2)) step();
    start = 1'b0;
    repeat (NV + LAT + 3) step();

    // srst wins over enable=0 and reseeds both LFSRs.
    enable = 1'b0;
    srst = 1'b1;
    step();
    srst = 1'b0;
    enable = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("first_u_after_srst", tb_u_n, model_step(SEED_U));
    check("first_v_after_srst", tb_v_n, model_step(SEED_V));
    repeat (NV + LAT + 3) step();

    // Long soak with start held and random enable gaps.
    vec_seen = 0;
    start = 1'b1;
    for (int i = 0; i < 30000 && vec_seen < 10000; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_format = 2'($urandom_range(0, 3));
      step();
    end
    check("soak_vectors", vec_seen >= 10000, 1);
    start = 1'b0;
    enable = 1'b1;
    repeat (NV + LAT + 3) step();
    check("du_seen_zero", seen_du[0] > 0, 1);
    check("du_seen_pos", seen_du[1] > 0, 1);
    check("du_seen_neg", seen_du[3] > 0, 1);
    check("dv_seen_zero", seen_dv[0] > 0, 1);
    check("dv_seen_pos", seen_dv[1] > 0, 1);
    check("dv_seen_neg", seen_dv[3] > 0, 1);

    // Async reset in the middle of a run.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && e != e0 + 4; i++) step();
    check("arst_reached_vec", e - e0, 4);
    #2 arst = 1'b0;
    #1;
    check("arst_vec_vld", vec_vld, 0);
    check("arst_chk_enable", chk_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_vec_cnt", vec_cnt, 0);
    check("arst_tb_n", tb_n, 0);
    check("arst_tb_u_n", tb_u_n, 0);
    check("arst_tb_v_n", tb_v_n, 0);
    model_reset();
    step();
    arst = 1'b1;
    repeat (NV + LAT + 3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_tb_n", tb_n, 0);
    check("restart_u", tb_u_n, model_step(SEED_U));
    repeat (NV + LAT + 3) step();
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bkm_control_step_stim.md
Name: bkm_control_step_stim

Overview:
Stimulus generator for the bkm_control_step testbench; the driving end of the interface the checker consumes.
- Produces one BKM step vector per enabled cycle: mode, format, n, digits d_u/d_v, operands u_n/v_n.
- Drives the DUT and the reference model.
- Emits a latency-aligned chk_enable so the checker samples the DUT result for the vector launched LATENCY cycles earlier.
- Sequences a run of NUM_VEC vectors with start/busy/done handshake.

Parameters:
W, 64, operand width; legal range 8..64.
LOG2N, 6, width of step index n; must match `LOG2N.
LATENCY, 1, DUT pipeline depth in cycles; legal range 0..8.
NUM_VEC, 1024, vectors per run; legal range 1..2^16-1.
SEED_U, 64'h0123_4567_89AB_CDEF, LFSR seed for u_n and the digits; must be non-zero.
SEED_V, 64'hFEDC_BA98_7654_3210, LFSR seed for v_n; must be non-zero.

Ports:
clk  in  1  clock, rising edge.
arst  in  1  asynchronous reset, active-low.
srst  in  1  synchronous reset, active-high.
enable  in  1  global advance; when low, all state holds.
start  in  1  begin a run; sampled only in IDLE.
cfg_mode  in  1  mode driven for the whole run; latched at start.
cfg_format  in  2  format driven for the whole run; latched at start.
tb_mode  out  1  vector mode.
tb_format  out  2  vector format.
tb_n  out  LOG2N  step index.
tb_d_u_n  out  2  u digit.
tb_d_v_n  out  2  v digit.
tb_u_n  out  W  u operand.
tb_v_n  out  W  v operand.
vec_vld  out  1  tb_* outputs hold a new vector this cycle.
chk_enable  out  1  vec_vld delayed by LATENCY enabled cycles; connects to checker enable.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse at end of run.
vec_cnt  out  16  vectors issued in the current run.

Behaviour:
- Reset (arst low, async) and srst (sync) have identical effect:
  - state=IDLE; all outputs 0.
  - LFSRs reloaded with SEED_U/SEED_V.
  - chk_enable delay line cleared.
- srst has priority over enable.
- FSM states: IDLE, RUN, DRAIN, DONE. Transitions happen only on enable=1 cycles.
  - IDLE: start=1 -> RUN. Latch cfg_mode/cfg_format; clear vec_cnt and tb_n.
  - RUN, each cycle:
    - vec_vld=1, vec_cnt++.
    - tb_n increments, wrapping 2^LOG2N-1 -> 0.
    - Both LFSRs advance one step.
    - When vec_cnt reaches NUM_VEC: go to DRAIN, or straight to DONE if LATENCY=0.
  - DRAIN: vec_vld=0; stays LATENCY cycles so chk_enable flushes -> DONE.
  - DONE: done=1 for one cycle -> IDLE. busy=0. LFSRs are not reseeded, so the next run continues the sequence.
- start is ignored outside IDLE; start held high in DONE/IDLE begins a new run the cycle after DONE.
- First vector appears the cycle after start is sampled. Vector k (0-based) carries tb_n = k mod 2^LOG2N.
- Outputs are registered. tb_u_n/tb_v_n/tb_d_* hold their last value when vec_vld=0 or enable=0.
- Operands:
  - tb_u_n = lfsr_u[W-1:0]; tb_v_n = lfsr_v[W-1:0].
  - LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, shifts right.
- Digits: encoding 00=0, 01=+1, 11=-1.
  - d_u is taken from lfsr_u[63:62]; d_v from lfsr_u[61:60].
  - Raw value 10 maps to 00, so 10 is never driven.
- Delay line: chk_enable is a LATENCY-deep shift register of vec_vld, shifting only when enable=1. With LATENCY=0, chk_enable=vec_vld combinationally.
- enable low mid-run freezes FSM, counters, LFSRs and delay line. The vector is held, with no duplicate vec_vld counted.
- Async reset mid-run aborts immediately; no done pulse.

Decomposition:
- Package bkm_tb_pkg holds:
  - digit encodings D_ZERO/D_POS/D_NEG;
  - FSM state encoding;
  - LFSR polynomial constant and default seeds.
- Sub-module bkm_lfsr64: 64-bit Galois LFSR with load, seed and advance.
  - Instantiated twice, once per operand.

Test Plan:
1. Reset, LATENCY=1, NUM_VEC=4, start pulse -> vec_vld high for 4 cycles with tb_n=0,1,2,3; chk_enable high one cycle later for 4 cycles; done pulse 1 cycle after the last chk_enable; vec_cnt=4.
2. LOG2N=2, NUM_VEC=6 -> tb_n sequence 0,1,2,3,0,1 (wrap).
3. enable low for 3 cycles during vector 2 of 4 -> tb_* and chk_enable frozen; total vec_vld count 4; done still issued.
4. Two runs with start held high -> second run's first tb_u_n equals the LFSR successor of the first run's last value, not SEED_U[W-1:0]; after srst the first tb_u_n equals the first advance of SEED_U.
5. 10,000 vectors -> tb_d_u_n and tb_d_v_n never 2'b10; every one of 00/01/11 is observed.
6. arst asserted mid-run at vector 5 -> all outputs 0 immediately; no done pulse; next start restarts with tb_n=0.
